// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - write-side handshake bundle for uart_tx_param
// Purpose: carries the word to transmit and its write/ready handshake.
// Signals:
//   DIN      word to transmit, LSB first on the line
//   WR_EN    write strobe; accepted when WR_EN and TX_READY are both 1
//   TX_READY holding register empty
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] DIN;
  logic                 WR_EN;
  logic                 TX_READY;

  modport master (output DIN, output WR_EN, input TX_READY);
  modport slave  (input DIN, input WR_EN, output TX_READY);
endinterface

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with one-word holding register
// Purpose: serialises DATA_BITS-wide words (LSB first) with optional odd/even
// parity and one or two stop bits, one bit per CLK_EN tick. A holding register
// lets the next word be queued while the current frame is on the line.
// Ports:
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   CLK_EN     baud tick, one single-cycle pulse per bit period
//   wr_if      write handshake (DIN, WR_EN in; TX_READY out)
//   TX         registered serial line, idle high
//   TX_BUSY    frame on the line or word pending
//   FRAME_DONE one-cycle pulse after the final stop tick
module uart_tx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLK_EN,
  uart_tx_param_if.slave   wr_if,
  output logic             TX,
  output logic             TX_BUSY,
  output logic             FRAME_DONE
);

  localparam int            CW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);
  // PARITY = 3 is treated as no parity.
  localparam bit            PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit            PAR_ODD  = (PARITY == 1);
  localparam bit            TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [CW-1:0]        r_cnt;
  logic                 r_stop_cnt;

  logic w_accept;
  logic w_hold_par;

  assign w_accept   = wr_if.WR_EN & ~r_hold_full;
  // The shifter is consumed bit by bit, so the parity of the word is captured
  // at the moment it moves from hold into the shifter.
  assign w_hold_par = (^r_hold) ^ PAR_ODD;

  assign wr_if.TX_READY = ~r_hold_full;
  assign TX_BUSY        = (r_state != S_IDLE) | r_hold_full;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_cnt       <= '0;
      r_stop_cnt  <= 1'b0;
      TX          <= 1'b1;
      FRAME_DONE  <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;

      // A write cannot coincide with a hold-to-shifter transfer: the transfer
      // needs hold_full = 1, which blocks acceptance in that cycle.
      if (w_accept) begin
        r_hold      <= wr_if.DIN;
        r_hold_full <= 1'b1;
      end

      if (CLK_EN) begin
        case (r_state)
          S_IDLE: begin
            if (r_hold_full) begin
              r_shift     <= r_hold;
              r_par       <= w_hold_par;
              r_hold_full <= 1'b0;
              TX          <= 1'b0;
              r_state     <= S_START;
            end
          end

          S_START: begin
            TX      <= r_shift[0];
            r_cnt   <= '0;
            r_state <= S_DATA;
          end

          S_DATA: begin
            if (r_cnt != LAST_IDX) begin
              // Shift right so the next bit to send is always at index 1.
              r_cnt   <= r_cnt + 1'b1;
              r_shift <= r_shift >> 1;
              TX      <= r_shift[1];
            end else if (PAR_EN) begin
              TX      <= r_par;
              r_state <= S_PAR;
            end else begin
              TX         <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= S_STOP;
            end
          end

          S_PAR: begin
            TX         <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end

          S_STOP: begin
            if (TWO_STOP && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              FRAME_DONE <= 1'b1;
              if (r_hold_full) begin
                // Back-to-back: next start bit follows with no idle bit.
                r_shift     <= r_hold;
                r_par       <= w_hold_par;
                r_hold_full <= 1'b0;
                TX          <= 1'b0;
                r_state     <= S_START;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end

          default: begin
            TX      <= 1'b1;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed self-checking bench for uart_tx_param
module tb_uart_tx_param;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b0;

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  uart_tx_param_if #(.DATA_BITS(8)) if_8e1 ();
  uart_tx_param_if #(.DATA_BITS(7)) if_7o2 ();
  uart_tx_param_if #(.DATA_BITS(8)) if_8n1 ();

  logic tx_8e1, busy_8e1, done_8e1;
  logic tx_7o2, busy_7o2, done_7o2;
  logic tx_8n1, busy_8n1, done_8n1;

  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .CLK(clk), .RST_N(rst_n), .CLK_EN(clk_en), .wr_if(if_8e1.slave),
    .TX(tx_8e1), .TX_BUSY(busy_8e1), .FRAME_DONE(done_8e1)
  );

  uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .CLK(clk), .RST_N(rst_n), .CLK_EN(clk_en), .wr_if(if_7o2.slave),
    .TX(tx_7o2), .TX_BUSY(busy_7o2), .FRAME_DONE(done_7o2)
  );

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .CLK(clk), .RST_N(rst_n), .CLK_EN(clk_en), .wr_if(if_8n1.slave),
    .TX(tx_8n1), .TX_BUSY(busy_8n1), .FRAME_DONE(done_8n1)
  );

  // sel: 0 = 8E1, 1 = 7O2, 2 = 8N1
  function automatic logic get_tx(input int sel);
    case (sel)
      0:       return tx_8e1;
      1:       return tx_7o2;
      default: return tx_8n1;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy_8e1;
      1:       return busy_7o2;
      default: return busy_8n1;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done_8e1;
      1:       return done_7o2;
      default: return done_8n1;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return if_8e1.TX_READY;
      1:       return if_7o2.TX_READY;
      default: return if_8n1.TX_READY;
    endcase
  endfunction

  // One idle cycle, then one tick cycle; returns at the negedge after the tick edge.
  task automatic do_tick();
    @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic write_word(input int sel, input logic [7:0] v);
    @(negedge clk);
    case (sel)
      0:       begin if_8e1.DIN = v;      if_8e1.WR_EN = 1'b1; end
      1:       begin if_7o2.DIN = v[6:0]; if_7o2.WR_EN = 1'b1; end
      default: begin if_8n1.DIN = v;      if_8n1.WR_EN = 1'b1; end
    endcase
    @(negedge clk);
    if_8e1.WR_EN = 1'b0;
    if_7o2.WR_EN = 1'b0;
    if_8n1.WR_EN = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_total++;
      if (get_tx(s) !== 1'b1) $display("FAIL reset_tx[%0d]: got %b want 1", s, get_tx(s));
      else n_pass++;
      n_total++;
      if (get_ready(s) !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", s, get_ready(s));
      else n_pass++;
      n_total++;
      if (get_busy(s) !== 1'b0 || get_done(s) !== 1'b0)
        $display("FAIL reset_busy_done[%0d]: got %b%b want 00", s, get_busy(s), get_done(s));
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      for (int s = 0; s < 3; s++) begin
        n_total++;
        if (get_tx(s) !== 1'b1 || get_busy(s) !== 1'b0)
          $display("FAIL idle_line[%0d] tick %0d: tx=%b busy=%b want tx=1 busy=0", s, i, get_tx(s), get_busy(s));
        else n_pass++;
      end
    end
  endtask

  task automatic test_8e1();
    int e[11];
    e = '{0, 1,0,1,0,0,1,0,1, 0, 1};
    write_word(0, 8'hA5);
    n_total++;
    if (get_ready(0) !== 1'b0 || get_busy(0) !== 1'b1)
      $display("FAIL 8e1_after_write: ready=%b busy=%b want ready=0 busy=1", get_ready(0), get_busy(0));
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      do_tick();
      n_total++;
      if (get_tx(0) !== 1'(e[i]) || get_done(0) !== 1'b0)
        $display("FAIL 8e1_bit%0d: tx=%b done=%b want tx=%0d done=0", i, get_tx(0), get_done(0), e[i]);
      else n_pass++;
    end
    do_tick();
    n_total++;
    if (get_done(0) !== 1'b1 || get_tx(0) !== 1'b1)
      $display("FAIL 8e1_done: done=%b tx=%b want 1 1", get_done(0), get_tx(0));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (get_done(0) !== 1'b0 || get_busy(0) !== 1'b0)
      $display("FAIL 8e1_after_done: done=%b busy=%b want 0 0", get_done(0), get_busy(0));
    else n_pass++;
  endtask

  task automatic test_7o2();
    int e[11];
    e = '{0, 1,0,0,0,0,0,1, 1, 1, 1};
    write_word(1, 8'h41);
    for (int i = 0; i < 11; i++) begin
      do_tick();
      n_total++;
      if (get_tx(1) !== 1'(e[i]) || get_done(1) !== 1'b0)
        $display("FAIL 7o2_bit%0d: tx=%b done=%b want tx=%0d done=0", i, get_tx(1), get_done(1), e[i]);
      else n_pass++;
    end
    do_tick();
    n_total++;
    if (get_done(1) !== 1'b1 || get_tx(1) !== 1'b1)
      $display("FAIL 7o2_done: done=%b tx=%b want 1 1", get_done(1), get_tx(1));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (get_busy(1) !== 1'b0)
      $display("FAIL 7o2_busy_end: busy=%b want 0", get_busy(1));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e1[10];
    int e2[10];
    e1 = '{0, 1,0,1,0,1,0,1,0, 1};
    e2 = '{0, 0,0,0,0,1,1,1,1, 1};
    write_word(2, 8'h55);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      n_total++;
      if (get_tx(2) !== 1'(e1[i]))
        $display("FAIL b2b_a_bit%0d: tx=%b want %0d", i, get_tx(2), e1[i]);
      else n_pass++;
    end
    n_total++;
    if (get_ready(2) !== 1'b1)
      $display("FAIL b2b_ready_after_load: got %b want 1", get_ready(2));
    else n_pass++;
    write_word(2, 8'hF0);
    n_total++;
    if (get_ready(2) !== 1'b0)
      $display("FAIL b2b_ready_on_second_write: got %b want 0", get_ready(2));
    else n_pass++;
    for (int i = 3; i < 10; i++) begin
      do_tick();
      n_total++;
      if (get_tx(2) !== 1'(e1[i]))
        $display("FAIL b2b_a_bit%0d: tx=%b want %0d", i, get_tx(2), e1[i]);
      else n_pass++;
    end
    do_tick();
    n_total++;
    if (get_done(2) !== 1'b1 || get_tx(2) !== 1'b0 || get_ready(2) !== 1'b1)
      $display("FAIL b2b_seam: done=%b tx=%b ready=%b want 1 0 1", get_done(2), get_tx(2), get_ready(2));
    else n_pass++;
    for (int i = 1; i < 10; i++) begin
      do_tick();
      n_total++;
      if (get_tx(2) !== 1'(e2[i]) || get_done(2) !== 1'b0)
        $display("FAIL b2b_b_bit%0d: tx=%b done=%b want tx=%0d done=0", i, get_tx(2), get_done(2), e2[i]);
      else n_pass++;
    end
    do_tick();
    n_total++;
    if (get_done(2) !== 1'b1 || get_tx(2) !== 1'b1)
      $display("FAIL b2b_b_done: done=%b tx=%b want 1 1", get_done(2), get_tx(2));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (get_busy(2) !== 1'b0)
      $display("FAIL b2b_busy_end: busy=%b want 0", get_busy(2));
    else n_pass++;
  endtask

  task automatic test_write_full();
    int e[10];
    e = '{0, 0,1,0,0,1,0,0,0, 1};
    write_word(2, 8'h12);
    write_word(2, 8'h34);
    n_total++;
    if (get_ready(2) !== 1'b0)
      $display("FAIL full_ready: got %b want 0", get_ready(2));
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      n_total++;
      if (get_tx(2) !== 1'(e[i]))
        $display("FAIL full_bit%0d: tx=%b want %0d", i, get_tx(2), e[i]);
      else n_pass++;
    end
    do_tick();
    n_total++;
    if (get_done(2) !== 1'b1 || get_tx(2) !== 1'b1)
      $display("FAIL full_done: done=%b tx=%b want 1 1", get_done(2), get_tx(2));
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      n_total++;
      if (get_tx(2) !== 1'b1 || get_busy(2) !== 1'b0)
        $display("FAIL full_dropped tick %0d: tx=%b busy=%b want 1 0", i, get_tx(2), get_busy(2));
      else n_pass++;
    end
  endtask

  task automatic test_same_edge();
    int e[10];
    e = '{0, 1,0,0,0,0,0,0,1, 1};
    @(negedge clk);
    if_8n1.DIN   = 8'h81;
    if_8n1.WR_EN = 1'b1;
    clk_en       = 1'b1;
    @(negedge clk);
    if_8n1.WR_EN = 1'b0;
    clk_en       = 1'b0;
    n_total++;
    if (get_tx(2) !== 1'b1 || get_ready(2) !== 1'b0 || get_busy(2) !== 1'b1)
      $display("FAIL same_edge_wait: tx=%b ready=%b busy=%b want 1 0 1", get_tx(2), get_ready(2), get_busy(2));
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      n_total++;
      if (get_tx(2) !== 1'(e[i]))
        $display("FAIL same_edge_bit%0d: tx=%b want %0d", i, get_tx(2), e[i]);
      else n_pass++;
    end
    do_tick();
    n_total++;
    if (get_done(2) !== 1'b1)
      $display("FAIL same_edge_done: got %b want 1", get_done(2));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int e[11];
    e = '{0, 1,1,1,1,0,0,0,0, 0, 1};
    write_word(0, 8'h33);
    repeat (4) do_tick();
    write_word(0, 8'h77);
    n_total++;
    if (get_tx(0) !== 1'b0 || get_ready(0) !== 1'b0)
      $display("FAIL mid_pre_reset: tx=%b ready=%b want 0 0", get_tx(0), get_ready(0));
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (get_tx(0) !== 1'b1 || get_ready(0) !== 1'b1 || get_busy(0) !== 1'b0 || get_done(0) !== 1'b0)
      $display("FAIL mid_reset: tx=%b ready=%b busy=%b done=%b want 1 1 0 0",
               get_tx(0), get_ready(0), get_busy(0), get_done(0));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    do_tick();
    n_total++;
    if (get_tx(0) !== 1'b1 || get_busy(0) !== 1'b0)
      $display("FAIL mid_pending_lost: tx=%b busy=%b want 1 0", get_tx(0), get_busy(0));
    else n_pass++;
    write_word(0, 8'h0F);
    for (int i = 0; i < 11; i++) begin
      do_tick();
      n_total++;
      if (get_tx(0) !== 1'(e[i]))
        $display("FAIL mid_clean_bit%0d: tx=%b want %0d", i, get_tx(0), e[i]);
      else n_pass++;
    end
    do_tick();
    n_total++;
    if (get_done(0) !== 1'b1)
      $display("FAIL mid_clean_done: got %b want 1", get_done(0));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (get_busy(0) !== 1'b0)
      $display("FAIL mid_clean_busy: got %b want 0", get_busy(0));
    else n_pass++;
  endtask

  initial begin
    if_8e1.DIN = '0; if_8e1.WR_EN = 1'b0;
    if_7o2.DIN = '0; if_7o2.WR_EN = 1'b0;
    if_8n1.DIN = '0; if_8n1.WR_EN = 1'b0;
    test_reset();
    test_8e1();
    test_7o2();
    test_back_to_back();
    test_write_full();
    test_same_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: next generation of the team's fixed 8N1 transmitter. It serialises words of configurable width with optional odd/even parity and one or two stop bits, advancing one bit per baud tick (`CLK_EN`). A one-word holding register decouples the writer from the shifter, which allows back-to-back frames with no idle gap. It sits between the system-side byte source and the pad, driven by the shared baud-tick generator.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even. The value 3 is illegal and behaves as none.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.

Ports:
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `CLK_EN`  in  1  baud tick; single-cycle pulse, one per bit period.
- `DIN`  in  DATA_BITS  word to transmit, sent LSB first.
- `WR_EN`  in  1  write strobe, active-high. A write is accepted when `WR_EN` and `TX_READY` are both 1.
- `TX_READY`  out  1  holding register empty.
- `TX`  out  1  serial line, registered, idle high.
- `TX_BUSY`  out  1  high while a frame is on the line or a word is pending.
- `FRAME_DONE`  out  1  one-cycle pulse at the end of each frame's last stop bit.

## Operation
- **Holding register.** An accepted write stores `DIN` and sets `hold_full`.
  - `TX_READY` = ~`hold_full`.
  - `WR_EN` while `TX_READY` = 0 is ignored and the pending word is kept.
- **State meaning.** The state encodes the bit currently on the line. Transitions happen only on cycles where `CLK_EN` = 1 ("tick"). `TX` updates on the same edge.
- **IDLE** (`TX` = 1)
  - Tick with `hold_full`: copy hold to shifter, clear `hold_full`, `TX` <= 0, go to START.
  - Tick with hold empty: no change.
- **START**
  - Tick: `TX` <= shifter[0], bit count <= 0, go to DATA.
- **DATA**
  - Tick with count < `DATA_BITS`-1: count++, `TX` <= shifter[count+1].
  - Tick with count = `DATA_BITS`-1, parity enabled: `TX` <= parity bit, go to PAR.
  - Tick with count = `DATA_BITS`-1, no parity: `TX` <= 1, stop count <= 0, go to STOP.
- **PAR**
  - Tick: `TX` <= 1, stop count <= 0, go to STOP.
- **STOP**
  - Tick with stop count < `STOP_BITS`-1: stop count++, `TX` stays 1.
  - Tick on the final stop bit: pulse `FRAME_DONE`.
    - If `hold_full`: load the shifter, `TX` <= 0, go to START (back-to-back frame).
    - Otherwise: go to IDLE.
- **Parity.** Even parity = XOR of the `DATA_BITS` data bits. Odd parity = its inverse. Computed from the shifter contents, so later writes to hold do not affect it.
- **Busy flag.** `TX_BUSY` = (state != IDLE) | `hold_full`.
- **Write during transfer.** A write in the same cycle as a hold-to-shifter transfer is not possible, because `TX_READY` was 0 that cycle. The write can be accepted from the next cycle.

## Timing
- **Reset values** (immediate on `RST_N` low, any cycle including mid-frame):
  - `TX` = 1, `TX_READY` = 1, `TX_BUSY` = 0, `FRAME_DONE` = 0.
  - State IDLE; the pending word and the in-flight frame are discarded.
- **Reset release.** First write is accepted on the first edge with `RST_N` high.
- **Write latency.** For a write at edge n:
  - `TX_READY` = 0 and `TX_BUSY` = 1 from n+1.
  - The start bit is driven at the first tick at edge ≥ n+1.
  - The same-edge case (`CLK_EN` = 1 together with the write at edge n) waits for the next tick.
- **Frame length.** 1 + `DATA_BITS` + (`PARITY` != 0) + `STOP_BITS` tick intervals. Each bit is held for exactly one tick interval.
- **Back-to-back frames.** With the hold loaded before the final stop tick, the next start bit follows that tick directly, with zero idle bits.
- **`FRAME_DONE`.** Asserted for the single cycle after the final stop tick edge.
- **`CLK_EN` stuck high.** One bit per `CLK` cycle; this is legal.

## Test plan
- **Reset defaults.** Hold `RST_N` low, then release → `TX` = 1, `TX_READY` = 1, `TX_BUSY` = 0; no line activity with no write.
- **8E1 frame.** Write `DIN` = 0xA5 with `DATA_BITS` = 8, `PARITY` = 2, `STOP_BITS` = 1 → line per tick: 0, 1,0,1,0,0,1,0,1, 0, 1. `FRAME_DONE` pulses once; `TX_BUSY` falls after it.
- **7O2 frame.** Write 0x41 with `DATA_BITS` = 7, `PARITY` = 1, `STOP_BITS` = 2 → line: 0, 1,0,0,0,0,0,1, 1 (odd parity), 1, 1. Total 11 ticks.
- **Back-to-back.** Write 0x55, then 0xF0 while the first frame is in DATA (8N1) → 0xF0's start bit immediately follows 0x55's stop bit. `TX_READY` deasserts on the second write and reasserts when 0xF0 enters the shifter.
- **Write when full.** Write 0x12, then 0x34 while `TX_READY` = 0 → only 0x12 is transmitted; 0x34 is dropped.
- **Reset mid-frame.** Assert `RST_N` low during DATA with a word pending → `TX` = 1 immediately and the pending word is lost. After release, a write of 0x0F transmits a clean frame.
